fft_scheduler: RTL and testbench

Time-shares one `fft` wrapper instance between `CH` ADC sample channels. Per-channel frame requests are queued, served round-robin, and the selected channel's samples are muxed onto the FFT input. The block then issues the FFT `start` pulse and tags the returned magnitude stream with channel and bin index for the display/frame-buffer writer downstream. It sits between the ADC capture front end and the `fft` block.

---
 rtl/fft_scheduler_pkg.sv | 37 +++
 rtl/fft_scheduler_arb.sv | 21 ++
 rtl/fft_scheduler.sv | 143 ++++++++++++++
 tb/tb_fft_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_scheduler_pkg.sv
// Shared types and helpers for the FFT time-sharing scheduler.
package fft_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_STREAM,
    S_GAP
  } sched_state_t;

  localparam int CH_MAX = 8;
  localparam int CW_MAX = $clog2(CH_MAX);

  // First pending channel at or after ptr, wrapping at ch; 0 when none pending.
  function automatic int rr_pick(input logic [CH_MAX-1:0] pending,
                                 input logic [CW_MAX-1:0] ptr,
                                 input int ch);
    int pick;
    int j;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < CH_MAX; i++) begin
      if (i < ch) begin
        j = int'(ptr) + i;
        if (j >= ch) j = j - ch;
        if (!found && pending[j[CW_MAX-1:0]]) begin
          pick  = j;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fft_scheduler_arb.sv
// Round-robin channel pick over the pending request vector.
module rr_arbiter
  import fft_sched_pkg::*;
#(
  parameter int CH = 2
) (
  input  logic [CH-1:0]         pending,
  input  logic [$clog2(CH)-1:0] rr_ptr,
  output logic [$clog2(CH)-1:0] pick,
  output logic                  gnt_vld
);

  logic [CH_MAX-1:0] pend_x;
  logic [CW_MAX-1:0] ptr_x;

  assign pend_x  = CH_MAX'(pending);
  assign ptr_x   = CW_MAX'(rr_ptr);
  assign pick    = $clog2(CH)'(rr_pick(pend_x, ptr_x, CH));
  assign gnt_vld = |pending;

endmodule

// File: rtl/fft_scheduler.sv
// Shares one FFT between CH sample channels: queues frame requests, serves
// them round-robin, and tags the returned magnitude stream with channel/bin.
module fft_scheduler
  import fft_sched_pkg::*;
#(
  parameter int CH      = 2,
  parameter int SN      = 12,
  parameter int RN      = 16,
  parameter int SIZE    = 256,
  parameter int GAP     = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    en,
  input  logic [CH-1:0]           ch_req,
  input  logic [SN-1:0]           ch_smpl [CH],
  output logic [SN-1:0]           fft_smpl,
  output logic                    fft_start,
  input  logic                    fft_valid,
  input  logic [RN-1:0]           fft_data,
  output logic                    out_valid,
  output logic [$clog2(CH)-1:0]   out_ch,
  output logic [$clog2(SIZE)-1:0] out_bin,
  output logic [RN-1:0]           out_data,
  output logic                    out_last,
  output logic [CH-1:0]           ch_done,
  output logic                    busy,
  output logic                    err
);

  localparam int CW   = $clog2(CH);
  localparam int BW   = $clog2(SIZE);
  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CNTW = $clog2(CMAX + 1);

  localparam logic [CNTW-1:0] TMO_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] GAP_LAST = CNTW'(GAP - 1);
  localparam logic [BW-1:0]   BIN_LAST = BW'(SIZE - 1);
  localparam logic [CW-1:0]   CH_LAST  = CW'(CH - 1);

  sched_state_t    state, state_nxt;
  logic [CH-1:0]   pending;
  logic [CW-1:0]   sel, rr_ptr, pick;
  logic            gnt_vld;
  logic [CNTW-1:0] cnt;
  logic [BW-1:0]   bin;
  logic            beat, last_beat, tmo;
  logic [CH-1:0]   done_vec;

  rr_arbiter #(.CH(CH)) u_arb (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .pick    (pick),
    .gnt_vld (gnt_vld)
  );

  assign fft_smpl  = ch_smpl[sel];
  assign fft_start = (state == S_START);
  assign busy      = (state != S_IDLE);
  assign done_vec  = last_beat ? (CH'(1) << sel) : '0;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // cnt is shared: Wait latency, Stream bubble run, and Gap length.
  always_comb begin
    state_nxt = state;
    beat      = 1'b0;
    last_beat = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE:  if (en && gnt_vld) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (fft_valid) begin
          beat      = 1'b1;
          state_nxt = S_STREAM;
        end else if (cnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_STREAM: begin
        if (fft_valid) begin
          beat = 1'b1;
          if (bin == BIN_LAST) begin
            last_beat = 1'b1;
            state_nxt = S_GAP;
          end
        end else if (cnt == TMO_LAST) begin
          tmo       = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP:   if (cnt == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt     <= '0;
      bin     <= '0;
      sel     <= '0;
      rr_ptr  <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      cnt     <= (state == S_IDLE || state_nxt != state || beat) ? '0 : cnt + 1'b1;
      // a request landing on the completion cycle wins and re-queues
      pending <= (pending & ~done_vec) | ch_req;
      if (state == S_START) bin <= '0;
      else if (beat)        bin <= bin + 1'b1;
      if (state == S_IDLE && state_nxt == S_START) sel <= pick;
      if (state == S_START) rr_ptr <= (sel == CH_LAST) ? '0 : sel + 1'b1;
      if (tmo) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_bin   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      ch_done   <= '0;
    end else begin
      out_valid <= beat;
      out_last  <= last_beat;
      ch_done   <= done_vec;
      if (beat) begin
        out_ch   <= sel;
        out_bin  <= bin;
        out_data <= fft_data;
      end
    end
  end

endmodule

// File: tb/tb_fft_scheduler.sv
// Directed bench for fft_scheduler with a queue-based output scoreboard.
module tb_fft_scheduler;

  localparam int CH = 2, SN = 12, RN = 16, SIZE = 8, GAP = 2, TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          en = 1'b0;
  logic [CH-1:0] ch_req = '0;
  logic [SN-1:0] ch_smpl [CH];
  logic [SN-1:0] fft_smpl;
  logic          fft_start;
  logic          fft_valid = 1'b0;
  logic [RN-1:0] fft_data = '0;
  logic          out_valid;
  logic [0:0]    out_ch;
  logic [2:0]    out_bin;
  logic [RN-1:0] out_data;
  logic          out_last;
  logic [CH-1:0] ch_done;
  logic          busy, err;

  always #5 clk = ~clk;

  fft_scheduler #(
    .CH(CH), .SN(SN), .RN(RN), .SIZE(SIZE), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_reset(n_reset), .en(en), .ch_req(ch_req), .ch_smpl(ch_smpl),
    .fft_smpl(fft_smpl), .fft_start(fft_start), .fft_valid(fft_valid),
    .fft_data(fft_data), .out_valid(out_valid), .out_ch(out_ch), .out_bin(out_bin),
    .out_data(out_data), .out_last(out_last), .ch_done(ch_done), .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [0:0]  ch;
    logic [2:0]  bin;
    logic [15:0] data;
    logic        last;
    logic [1:0]  done;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int vectors = 0;
  int miscomp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [CH-1:0] m);
    ch_req = m;
    tick();
    ch_req = '0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!fft_start && n < 64) begin
      tick();
      n++;
    end
    chk("fft_start seen", fft_start, 1);
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (busy && k < 64) begin
      tick();
      k++;
    end
    chk("return to idle", busy, 0);
  endtask

  // Called in the fft_start cycle; plays the FFT side and queues expected beats.
  task automatic run_frame(input int ch, input int nbeats, input int bubble,
                           input logic [15:0] base);
    beat_t e;
    chk("fft_smpl mux", fft_smpl, ch_smpl[ch]);
    tick();
    for (int i = 0; i < nbeats; i++) begin
      fft_valid = 1'b1;
      fft_data  = base + 16'(i);
      e.ch   = 1'(ch);
      e.bin  = 3'(i);
      e.data = fft_data;
      e.last = (i == SIZE - 1);
      e.done = e.last ? 2'(1 << ch) : 2'b00;
      exp_q.push_back(e);
      tick();
      fft_valid = 1'b0;
      if (i < nbeats - 1) repeat (bubble) tick();
    end
  endtask

  task automatic serve(input int ch, input int bubble, input logic [15:0] base);
    int n;
    wait_start(n);
    run_frame(ch, SIZE, bubble, base);
  endtask

  always @(negedge clk) begin
    if (n_reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected out_valid", out_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("out beat {ch,bin,data,last,done}",
              {out_ch, out_bin, out_data, out_last, ch_done}, mon_e);
        end
      end else begin
        chk("ch_done without beat", ch_done, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic saw;
    ch_smpl[0] = 12'h123;
    ch_smpl[1] = 12'h9AB;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst fft_start", fft_start, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst ch_done", ch_done, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("rst out_bin", out_bin, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_last", out_last, 0);
    chk("rst out_ch", out_ch, 0);
    chk("rst fft_smpl", fft_smpl, 12'h123);
    n_reset = 1'b1;
    tick();

    // simultaneous requests from rr_ptr=0: ch0 then ch1
    issue(2'b11);
    wait_start(n);
    chk("start latency 11", n, 1);
    run_frame(0, SIZE, 0, 16'h1000);
    serve(1, 0, 16'h1100);
    wait_idle();

    // single request, re-requested on its own out_last cycle
    issue(2'b01);
    wait_start(n);
    chk("start latency 01", n, 1);
    run_frame(0, SIZE, 0, 16'h2000);
    issue(2'b01);
    wait_start(n);
    chk("re-request spacing", n, 2);
    run_frame(0, SIZE, 0, 16'h2100);
    wait_idle();

    // rr_ptr now 1: ch1 then ch0
    issue(2'b11);
    wait_start(n);
    chk("start latency 11 ptr1", n, 1);
    run_frame(1, SIZE, 0, 16'h3000);
    serve(0, 0, 16'h3100);
    wait_idle();

    // 3-cycle bubbles between beats
    issue(2'b10);
    serve(1, 3, 16'h4000);
    wait_idle();
    chk("err after bubbles", err, 0);

    // 16-cycle bubble aborts after bin 2; request retried
    issue(2'b01);
    wait_start(n);
    run_frame(0, 3, 0, 16'h5000);
    repeat (15) tick();
    chk("err before abort", err, 0);
    tick();
    chk("err after abort", err, 1);
    serve(0, 0, 16'h5100);
    wait_idle();

    // reset clears sticky err; then Wait timeout with no valid beats
    n_reset = 1'b0;
    tick();
    chk("err cleared by reset", err, 0);
    n_reset = 1'b1;
    tick();
    issue(2'b01);
    wait_start(n);
    chk("start latency tmo", n, 1);
    repeat (15) tick();
    chk("err before timeout", err, 0);
    repeat (2) tick();
    chk("err after timeout", err, 1);
    wait_start(n);
    chk("timeout retry spacing", n, GAP + 1);
    run_frame(0, SIZE, 0, 16'h6000);
    wait_idle();

    // asynchronous reset mid-Stream
    issue(2'b10);
    wait_start(n);
    run_frame(1, 3, 0, 16'h7000);
    tick();
    #2 n_reset = 1'b0;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst out_bin", out_bin, 0);
    chk("mid rst out_data", out_data, 0);
    chk("mid rst out_ch", out_ch, 0);
    chk("mid rst fft_smpl", fft_smpl, 12'h123);
    tick();
    n_reset = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      tick();
      saw |= fft_start;
    end
    chk("no start after reset", saw, 0);

    // en low holds requests in pending
    en = 1'b0;
    issue(2'b10);
    saw = 1'b0;
    repeat (5) begin
      tick();
      saw |= fft_start;
    end
    chk("no start while en=0", saw, 0);
    chk("idle while en=0", busy, 0);
    en = 1'b1;
    wait_start(n);
    chk("start after en", n, 1);
    run_frame(1, SIZE, 0, 16'h8000);
    wait_idle();
    repeat (2) tick();

    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

endmodule
